// File: rtl/floating_point_accumulator.sv
// floating_point_accumulator: streaming floating-point summation of a term stream.
// Terms of one vector are added into a single-cycle feedback accumulator. The last term
// of a vector publishes the sum and term count as a one-cycle valid_o pulse.
// Optional status_o port: define FP_ACCUMULATOR_STATUS_EN.
module floating_point_accumulator #(
  parameter int unsigned EXP_WIDTH    = 8,
  parameter int unsigned FRAC_WIDTH   = 23,
  parameter int unsigned COUNT_WIDTH  = 16,
  localparam int unsigned FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [FP_WIDTH_REG-1:0] fp_i,
  input  logic                    valid_i,
  input  logic                    last_i,
  output logic [FP_WIDTH_REG-1:0] sum_o,
  output logic [COUNT_WIDTH-1:0]  count_o,
  output logic                    valid_o
`ifdef FP_ACCUMULATOR_STATUS_EN
  ,
  output logic [1:0]              status_o
`endif
);

  localparam int unsigned MW = FRAC_WIDTH + 3;  // {carry, lead, frac, round}
  localparam int unsigned RW = FRAC_WIDTH + 2;  // {carry, lead, frac} after rounding
  localparam int unsigned EW = EXP_WIDTH + 2;   // two's-complement exponent workspace
  localparam logic [EXP_WIDTH-1:0] EXP_MAX = '1;

  logic [FP_WIDTH_REG-1:0] term_q;
  logic                    valid_q;
  logic                    last_q;
  logic [FP_WIDTH_REG-1:0] acc_q;
  logic [COUNT_WIDTH-1:0]  cnt_q;

  logic [FP_WIDTH_REG-1:0] add_res;

  logic                  a_sign, b_sign, a_spec, b_spec;
  logic [EXP_WIDTH-1:0]  a_exp, b_exp;
  logic [FRAC_WIDTH-1:0] a_frac, b_frac;
  logic                  swap, big_sign;
  logic [EXP_WIDTH-1:0]  big_exp, small_exp;
  logic [FRAC_WIDTH-1:0] big_frac, small_frac;
  logic [31:0]           exp_diff;
  logic [MW-1:0]         big_m, small_m, small_al, raw;
  logic [MW-2:0]         norm;
  logic [RW-1:0]         rnd;
  logic [EW-1:0]         exp_work;
  logic [FRAC_WIDTH-1:0] frac_fin;
  int                    lz;

  // Combinational add of the accumulator (operand a) and the registered term (operand b)
  always_comb begin
    a_sign = acc_q[FP_WIDTH_REG-1];
    a_exp  = acc_q[FP_WIDTH_REG-2 -: EXP_WIDTH];
    a_frac = (a_exp == '0) ? '0 : acc_q[FRAC_WIDTH-1:0];
    a_spec = (a_exp == EXP_MAX);
    b_sign = term_q[FP_WIDTH_REG-1];
    b_exp  = term_q[FP_WIDTH_REG-2 -: EXP_WIDTH];
    b_frac = (b_exp == '0) ? '0 : term_q[FRAC_WIDTH-1:0];
    b_spec = (b_exp == EXP_MAX);

    // Order operands by magnitude; the larger one sets the result sign
    swap       = {b_exp, b_frac} > {a_exp, a_frac};
    big_sign   = swap ? b_sign : a_sign;
    big_exp    = swap ? b_exp  : a_exp;
    big_frac   = swap ? b_frac : a_frac;
    small_exp  = swap ? a_exp  : b_exp;
    small_frac = swap ? a_frac : b_frac;

    exp_diff = 32'(big_exp) - 32'(small_exp);
    big_m    = {1'b0, big_exp != '0, big_frac, 1'b0};
    small_m  = {1'b0, small_exp != '0, small_frac, 1'b0};
    if (exp_diff >= 32'(FRAC_WIDTH + 2)) begin
      small_al = '0;
    end else begin
      small_al = small_m >> exp_diff;
    end
    raw = (a_sign == b_sign) ? big_m + small_al : big_m - small_al;

    // Leading-one detect below the carry bit; highest set bit wins
    lz = 0;
    for (int i = 0; i < int'(MW) - 1; i++) begin
      if (raw[i]) lz = int'(MW) - 2 - i;
    end

    if (raw[MW-1]) begin
      norm     = raw[MW-1:1];
      exp_work = {2'b00, big_exp} + EW'(1);
    end else begin
      norm     = raw[MW-2:0] << lz;
      exp_work = {2'b00, big_exp} - EW'(lz);
    end

    // Round half-up on the round bit; a carry out renormalises
    rnd = RW'(norm[MW-2:1]) + RW'(norm[0]);
    if (rnd[RW-1]) begin
      frac_fin = rnd[RW-2:1];
      exp_work = exp_work + EW'(1);
    end else begin
      frac_fin = rnd[FRAC_WIDTH-1:0];
    end

    if (a_spec || b_spec) begin
      add_res = {(a_spec ? a_sign : b_sign), EXP_MAX, {FRAC_WIDTH{1'b0}}};
    end else if (raw == '0) begin
      add_res = '0;
    end else if (exp_work[EW-1] || (exp_work == '0)) begin
      add_res = {big_sign, {(FP_WIDTH_REG-1){1'b0}}};
    end else if (exp_work >= {2'b00, EXP_MAX}) begin
      add_res = {big_sign, EXP_MAX, {FRAC_WIDTH{1'b0}}};
    end else begin
      add_res = {big_sign, exp_work[EXP_WIDTH-1:0], frac_fin};
    end
  end

  // Input stage: capture the term and its qualifiers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      term_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      term_q  <= fp_i;
      valid_q <= valid_i;
      last_q  <= last_i;
    end
  end

  // Accumulate valid terms; the last term publishes the sum and restarts from +0
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_o   <= '0;
      count_o <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (valid_q) begin
        if (last_q) begin
          sum_o   <= add_res;
          count_o <= cnt_q + COUNT_WIDTH'(1);
          valid_o <= 1'b1;
          acc_q   <= '0;
          cnt_q   <= '0;
        end else begin
          acc_q   <= add_res;
          cnt_q   <= cnt_q + COUNT_WIDTH'(1);
        end
      end
    end
  end

`ifdef FP_ACCUMULATOR_STATUS_EN
  logic add_ovf, add_uflw;
  logic ovf_q, uflw_q;

  // A result exponent of EXP_MAX only arises from saturation or Inf/NaN propagation;
  // a zero magnitude from a nonzero raw sum only arises from flush-to-zero.
  assign add_ovf  = (add_res[FP_WIDTH_REG-2 -: EXP_WIDTH] == EXP_MAX);
  assign add_uflw = !(a_spec || b_spec) && (raw != '0) && (add_res[FP_WIDTH_REG-2:0] == '0);

  // Sticky per-vector flags, published alongside sum_o
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q    <= 1'b0;
      uflw_q   <= 1'b0;
      status_o <= 2'b00;
    end else if (valid_q) begin
      if (last_q) begin
        status_o <= {ovf_q | add_ovf, uflw_q | add_uflw};
        ovf_q    <= 1'b0;
        uflw_q   <= 1'b0;
      end else begin
        ovf_q    <= ovf_q | add_ovf;
        uflw_q   <= uflw_q | add_uflw;
      end
    end
  end
`endif

endmodule

// File: tb/tb_floating_point_accumulator.sv
// Bench for floating_point_accumulator: directed vectors plus randomized vectors, a
// scoreboard queue filled by the driver and drained by an output monitor.
module tb_floating_point_accumulator;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] fp_i;
  logic        valid_i;
  logic        last_i;
  logic [31:0] sum_o;
  logic [15:0] count_o;
  logic        valid_o;
`ifdef FP_ACCUMULATOR_STATUS_EN
  logic [1:0]  status_o;
`endif

  floating_point_accumulator #(
    .EXP_WIDTH  (8),
    .FRAC_WIDTH (23),
    .COUNT_WIDTH(16)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .fp_i    (fp_i),
    .valid_i (valid_i),
    .last_i  (last_i),
    .sum_o   (sum_o),
    .count_o (count_o),
    .valid_o (valid_o)
`ifdef FP_ACCUMULATOR_STATUS_EN
    ,
    .status_o(status_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] sum;
    logic [15:0] cnt;
    logic [1:0]  st;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;

  logic [31:0] m_acc;
  int          m_cnt;
  bit          m_ovf, m_uflw;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // Reference sum of two binary32 values: exact significands with the smaller one
  // truncated to one bit below the LSB, renormalised and rounded half-up.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b,
                                         output bit ovf, output bit uflw);
    int     ea, eb, el, es, d, p, e;
    longint ma, mb, ml, ms, ml2, ms2, r, t, sig;
    bit     sl;
    ovf  = 0;
    uflw = 0;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 255 || eb == 255) begin
      ovf = 1;
      return {((ea == 255) ? a[31] : b[31]), 8'hFF, 23'h0};
    end
    ma = (ea == 0) ? 0 : (longint'(a[22:0]) + (longint'(1) << 23));
    mb = (eb == 0) ? 0 : (longint'(b[22:0]) + (longint'(1) << 23));
    if (ea > eb || (ea == eb && ma >= mb)) begin
      el = ea; ml = ma; sl = a[31]; es = eb; ms = mb;
    end else begin
      el = eb; ml = mb; sl = b[31]; es = ea; ms = ma;
    end
    d   = el - es;
    ml2 = ml * 2;
    ms2 = (d >= 25) ? 0 : ((ms * 2) >> d);
    r   = (a[31] == b[31]) ? ml2 + ms2 : ml2 - ms2;
    if (r == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 64; i++) if (r[i]) p = i;
    e   = el + p - 24;
    t   = (p >= 24) ? (r >> (p - 24)) : (r << (24 - p));
    sig = (t >> 1) + (t & 1);
    if (sig == (longint'(1) << 24)) begin
      sig = sig >> 1;
      e++;
    end
    if (e <= 0) begin
      uflw = 1;
      return {sl, 31'h0};
    end
    if (e >= 255) begin
      ovf = 1;
      return {sl, 8'hFF, 23'h0};
    end
    return {sl, 8'(e), 23'(sig)};
  endfunction

  function automatic logic [31:0] rand_term();
    int         k;
    logic [7:0] e;
    k = int'($urandom_range(0, 99));
    if (k < 4)       e = 8'd0;
    else if (k < 6)  e = 8'hFF;
    else if (k < 10) e = 8'($urandom_range(240, 254));
    else if (k < 14) e = 8'($urandom_range(1, 12));
    else             e = 8'($urandom_range(118, 136));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  task automatic model_clear();
    m_acc  = 32'h0;
    m_cnt  = 0;
    m_ovf  = 0;
    m_uflw = 0;
  endtask

  // Drive one valid term for a cycle and update the reference model
  task automatic send(input logic [31:0] t, input bit last);
    bit   o, u;
    exp_t e;
    fp_i    = t;
    valid_i = 1'b1;
    last_i  = last;
    m_acc   = fp_add(m_acc, t, o, u);
    m_cnt++;
    m_ovf   = m_ovf | o;
    m_uflw  = m_uflw | u;
    if (last) begin
      e.sum = m_acc;
      e.cnt = 16'(m_cnt);
      e.st  = {m_ovf, m_uflw};
      e.cyc = cyc + 2;
      sbq.push_back(e);
      model_clear();
    end
    @(posedge clk_i);
    #1;
  endtask

  // Idle cycles carry junk on fp_i/last_i that must be ignored
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      valid_i = 1'b0;
      fp_i    = $urandom;
      last_i  = 1'($urandom_range(0, 1));
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic expect_last(input string name, input logic [31:0] s, input logic [1:0] st);
    check({name, "_ref_sum"}, {32'h0, sbq[$].sum}, {32'h0, s});
    check({name, "_ref_status"}, {62'h0, sbq[$].st}, {62'h0, st});
  endtask

  task automatic do_reset();
    valid_i = 1'b0;
    last_i  = 1'b0;
    rst_i   = 1'b1;
    repeat (2) begin
      @(posedge clk_i);
      #1;
    end
    rst_i = 1'b0;
    model_clear();
    @(negedge clk_i);
    check("reset_valid_o", {63'h0, valid_o}, 64'h0);
    check("reset_sum_o", {32'h0, sum_o}, 64'h0);
    check("reset_count_o", {48'h0, count_o}, 64'h0);
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: every valid_o pulse must match the oldest outstanding expectation
  always @(negedge clk_i) begin
    if (valid_o) begin
      if (sbq.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_valid: got valid_o=1 at cycle %0d, required 0", cyc);
      end else begin
        mon_e = sbq.pop_front();
        check("sum_o", {32'h0, sum_o}, {32'h0, mon_e.sum});
        check("count_o", {48'h0, count_o}, {48'h0, mon_e.cnt});
        check("latency", 64'(cyc), 64'(mon_e.cyc));
`ifdef FP_ACCUMULATOR_STATUS_EN
        check("status_o", {62'h0, status_o}, {62'h0, mon_e.st});
`endif
      end
    end
  end

  initial begin
    int len;
    rst_i   = 1'b1;
    valid_i = 1'b0;
    last_i  = 1'b0;
    fp_i    = 32'h0;
    model_clear();
    repeat (3) @(posedge clk_i);
    #1;
    do_reset();

    // 1 + 2 + 3
    send(32'h3F800000, 0);
    send(32'h40000000, 0);
    send(32'h40400000, 1);
    expect_last("v_sum6", 32'h40C00000, 2'b00);
    idle(2);
    // exact cancellation
    send(32'h3FC00000, 0);
    send(32'hBFC00000, 1);
    expect_last("v_cancel", 32'h00000000, 2'b00);
    idle(1);
    // overflow saturates
    send(32'h7F000000, 0);
    send(32'h7F000000, 1);
    expect_last("v_ovf", 32'h7F800000, 2'b10);
    idle(3);
    // subnormal flushed, gaps inside the vector
    send(32'h3F800000, 0);
    idle(2);
    send(32'h00000001, 1);
    expect_last("v_subn", 32'h3F800000, 2'b00);
    idle(2);
    // single-term vectors back to back
    send(32'h40000000, 1);
    send(32'h40800000, 1);
    idle(2);
    // reset mid-vector discards the partial sum
    send(32'h3F800000, 0);
    send(32'h3F800000, 0);
    do_reset();
    send(32'h40400000, 1);
    expect_last("v_rst", 32'h40400000, 2'b00);
    idle(3);

    // randomized vectors
    for (int v = 0; v < 80; v++) begin
      len = int'($urandom_range(1, 8));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        send(rand_term(), i == len - 1);
      end
      if ($urandom_range(0, 2) == 0) idle(1);
    end
    valid_i = 1'b0;
    last_i  = 1'b0;

    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk_i);
    @(negedge clk_i);
    check("drain_outstanding", 64'(sbq.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
